row_fetch_seq: RTL and testbench

ROW_FETCH_SEQ -- requirements
Module: row_fetch_seq

---
 rtl/row_fetch_seq_pkg.sv | 13 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/row_fetch_seq.sv | 155 +++++++++++++++
 tb/tb_row_fetch_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_fetch_seq_pkg.sv
// Shared definitions for the row fetch sequencer: FSM encoding and row width.
package row_fetch_seq_pkg;

   localparam int ROW_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags; a push on a full FIFO
// is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_L,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_nxt;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      count_nxt = count_q;
      if (do_push && !do_pop) begin
         count_nxt = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_nxt = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_nxt;
         full    <= (count_nxt == CNT_W'(DEPTH));
         empty   <= (count_nxt == '0);
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/row_fetch_seq.sv
// Fetches a window of reference rows from memory and streams them, in
// request order, to a downstream shift register through a small return FIFO.
//
//   state | meaning
//   IDLE  | waiting for start; stray read data flags overflow
//   FETCH | issuing reads, throttled to FIFO_DEPTH outstanding
//   DRAIN | all reads issued, delivering remaining rows
//   DONE  | one-cycle window_valid pulse
module row_fetch_seq
   import row_fetch_seq_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int ROW_STRIDE = 64,
   parameter int NUM_ROWS   = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset_L,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_gnt,
   input  logic              mem_rd_valid,
   input  logic [ROW_W-1:0]  mem_rd_data,
   input  logic              out_ready,
   output logic [ROW_W-1:0]  row_out,
   output logic              load_L,
   output logic              window_valid,
   output logic              overflow_err
);

   localparam int CNT_W = $clog2(NUM_ROWS + 1);
   localparam int OUT_W = $clog2(FIFO_DEPTH + 1);

   fetch_state_t      state_q;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  issued_q;
   logic [CNT_W-1:0]  popped_q;
   logic [OUT_W-1:0]  outstanding_q;
   logic [ROW_W-1:0]  row_q;
   logic              load_L_q;
   logic              ovf_q;

   logic              start_acc;
   logic              issue;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ROW_W-1:0]  fifo_data;

   assign start_acc = (state_q == ST_IDLE) & start;
   assign issue     = mem_rd_req & mem_rd_gnt;
   assign push      = mem_rd_valid & (state_q != ST_IDLE);
   assign pop       = ~fifo_empty & out_ready;

   always_comb begin
      state_nxt  = state_q;
      mem_rd_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            mem_rd_req = (outstanding_q < OUT_W'(FIFO_DEPTH));
            if (mem_rd_req && mem_rd_gnt && (issued_q == CNT_W'(NUM_ROWS - 1))) begin
               state_nxt = ST_DRAIN;
            end
         end
         // Leave one edge after the final pop so window_valid follows the
         // last load strobe rather than overlapping it.
         ST_DRAIN: begin
            if (popped_q == CNT_W'(NUM_ROWS)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         addr_q        <= '0;
         issued_q      <= '0;
         popped_q      <= '0;
         outstanding_q <= '0;
      end else if (start_acc) begin
         addr_q        <= base_addr;
         issued_q      <= '0;
         popped_q      <= '0;
         outstanding_q <= '0;
      end else begin
         if (issue) begin
            addr_q   <= addr_q + ADDR_W'(ROW_STRIDE);
            issued_q <= issued_q + 1'b1;
         end
         if (pop) popped_q <= popped_q + 1'b1;
         case ({issue, pop})
            2'b10:   outstanding_q <= outstanding_q + 1'b1;
            2'b01:   outstanding_q <= outstanding_q - 1'b1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         row_q    <= '0;
         load_L_q <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         load_L_q <= ~pop;
         if (pop) row_q <= fifo_data;
         if (mem_rd_valid && ((state_q == ST_IDLE) || (fifo_full && !pop))) begin
            ovf_q <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (FIFO_DEPTH)
   ) u_ret_fifo (
      .clock   (clock),
      .reset_L (reset_L),
      .push    (push),
      .wr_data (mem_rd_data),
      .pop     (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign busy         = (state_q != ST_IDLE);
   assign window_valid = (state_q == ST_DONE);
   assign mem_rd_addr  = addr_q;
   assign row_out      = row_q;
   assign load_L       = load_L_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_row_fetch_seq.sv
// Directed bench for row_fetch_seq: a window-level model checks every request
// address, every delivered row and the overflow flag each cycle.
module tb_row_fetch_seq;

   localparam int ADDR_W     = 16;
   localparam int ROW_STRIDE = 64;
   localparam int NUM_ROWS   = 15;
   localparam int FIFO_DEPTH = 4;

   localparam int MODE_NOM   = 0;
   localparam int MODE_WRAP  = 1;
   localparam int MODE_BP    = 2;
   localparam int MODE_STALL = 3;
   localparam int MODE_RST   = 4;

   logic              clock = 1'b0;
   logic              reset_L = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              busy;
   logic              mem_rd_req;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              mem_rd_gnt = 1'b1;
   logic              mem_rd_valid = 1'b0;
   logic [63:0]       mem_rd_data = '0;
   logic              out_ready = 1'b1;
   logic [63:0]       row_out;
   logic              load_L;
   logic              window_valid;
   logic              overflow_err;

   row_fetch_seq #(
      .ADDR_W     (ADDR_W),
      .ROW_STRIDE (ROW_STRIDE),
      .NUM_ROWS   (NUM_ROWS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clock        (clock),
      .reset_L      (reset_L),
      .start        (start),
      .base_addr    (base_addr),
      .busy         (busy),
      .mem_rd_req   (mem_rd_req),
      .mem_rd_addr  (mem_rd_addr),
      .mem_rd_gnt   (mem_rd_gnt),
      .mem_rd_valid (mem_rd_valid),
      .mem_rd_data  (mem_rd_data),
      .out_ready    (out_ready),
      .row_out      (row_out),
      .load_L       (load_L),
      .window_valid (window_valid),
      .overflow_err (overflow_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // window model state
   logic [ADDR_W-1:0] m_base = '0;
   bit   m_busy = 0;
   bit   exp_ovf = 0;
   bit   chk_en = 0;
   bit   prev_load_low = 0;
   bit   mem_en = 1;
   bit   inj_req = 0;
   int   n_iss = 0, n_load = 0, n_wv = 0, t0 = 0;
   int   first_req = -1, last_req = -1, first_load = -1, last_load = -1;
   int   wv_rel = -1, busy_fall = -1, stall_hold = 0;
   logic [ADDR_W-1:0] req_addr [16];
   logic [63:0] first_row = '0;
   int   bp_iss = 0, bp_req_cnt = 0;

   function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] base, input int k);
      return base + ADDR_W'(k * ROW_STRIDE);
   endfunction

   // Memory contents: each word is a distinct function of its address.
   function automatic logic [63:0] mem_word(input logic [ADDR_W-1:0] a);
      return {a, ~a, a ^ 16'h5A5A, a + 16'h1234};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      int rel;
      forever begin
         @(negedge clock);
         if (!reset_L) begin
            m_busy = 0;
            n_iss = 0;
            n_load = 0;
            prev_load_low = 0;
         end else begin
            if (start && !m_busy) begin
               m_busy = 1; m_base = base_addr; t0 = cyc;
               n_iss = 0; n_load = 0; n_wv = 0; stall_hold = 0;
               first_req = -1; last_req = -1; first_load = -1; last_load = -1;
               wv_rel = -1; busy_fall = -1;
            end
            rel = cyc - t0;
            if (chk_en) begin
               if (!m_busy) chk("no_req_when_idle", {63'd0, mem_rd_req}, 64'd0);
               if (mem_rd_req) begin
                  chk("req_count_bound", {63'd0, n_iss < NUM_ROWS}, 64'd1);
                  chk("rd_addr", {48'd0, mem_rd_addr}, {48'd0, model_addr(m_base, n_iss)});
                  if (n_iss == 7) stall_hold++;
                  if (mem_rd_gnt) begin
                     if (n_iss < 16) req_addr[n_iss] = mem_rd_addr;
                     if (first_req < 0) first_req = rel;
                     last_req = rel;
                     n_iss++;
                  end
               end
               if (!load_L) begin
                  chk("row_dup_bound", {63'd0, n_load < NUM_ROWS}, 64'd1);
                  chk("row_out", row_out, mem_word(model_addr(m_base, n_load)));
                  if (n_load == 0) first_row = row_out;
                  if (first_load < 0) first_load = rel;
                  last_load = rel;
                  n_load++;
               end
               if (window_valid) begin
                  chk("wv_all_rows", 64'(n_load), 64'(NUM_ROWS));
                  chk("wv_after_last_load", {63'd0, prev_load_low}, 64'd1);
                  n_wv++;
                  wv_rel = rel;
                  m_busy = 0;
               end else if (wv_rel >= 0 && busy_fall < 0 && !busy) begin
                  busy_fall = rel;
               end
               chk("overflow_err", {63'd0, overflow_err}, {63'd0, exp_ovf});
            end
            prev_load_low = !load_L;
         end
      end
   endtask

   // Read-latency-1 memory: a grant seen this cycle returns data next cycle.
   task automatic mem_loop();
      bit g, inj;
      logic [ADDR_W-1:0] a;
      forever begin
         @(negedge clock);
         g = mem_rd_req && mem_rd_gnt && reset_L;
         a = mem_rd_addr;
         inj = inj_req;
         @(posedge clock);
         #1;
         mem_rd_valid = (g && mem_en) || inj;
         mem_rd_data  = g ? mem_word(a) : 64'hDEAD_BEEF_0BAD_F00D;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},   {63'd0, busy},         64'd0);
      chk({tag, "_req"},    {63'd0, mem_rd_req},   64'd0);
      chk({tag, "_addr"},   {48'd0, mem_rd_addr},  64'd0);
      chk({tag, "_row"},    row_out,               64'd0);
      chk({tag, "_load_L"}, {63'd0, load_L},       64'd1);
      chk({tag, "_wv"},     {63'd0, window_valid}, 64'd0);
      chk({tag, "_ovf"},    {63'd0, overflow_err}, 64'd0);
   endtask

   task automatic drive_window(input logic [ADDR_W-1:0] base, input int mode);
      bit done_ok;
      int stall_cnt;
      done_ok = 0;
      stall_cnt = 0;
      bp_iss = 0;
      bp_req_cnt = 0;
      @(posedge clock); #1;
      start = 1'b1; base_addr = base;
      @(posedge clock); #1;
      start = 1'b0; base_addr = 16'hBEEF;
      for (int r = 1; r < 150; r++) begin
         if ((mode == MODE_RST && n_load >= 6) || (n_wv >= 1 && !busy)) begin
            done_ok = 1;
            break;
         end
         mem_rd_gnt = 1'b1;
         out_ready  = 1'b1;
         start      = 1'b0;
         if (mode == MODE_BP && r >= 3 && r < 40) out_ready = 1'b0;
         if (mode == MODE_BP && r == 39) bp_iss = n_iss;
         if (mode == MODE_BP && r >= 8 && r < 40 && mem_rd_req) bp_req_cnt++;
         if (mode == MODE_STALL && n_iss == 7 && stall_cnt < 5) begin
            mem_rd_gnt = 1'b0;
            stall_cnt++;
         end
         if ((mode == MODE_WRAP && r == 6) || (mode == MODE_STALL && window_valid)) begin
            start = 1'b1;
            base_addr = 16'h7777;
         end
         @(posedge clock); #1;
      end
      start = 1'b0; mem_rd_gnt = 1'b1; out_ready = 1'b1;
      chk("window_completes", {63'd0, done_ok}, 64'd1);
   endtask

   task automatic inject_valid();
      @(posedge clock); #3; inj_req = 1;
      @(posedge clock); #3; inj_req = 0;
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      fork
         compare_loop();
         mem_loop();
         begin
            #500000;
            $display("FAIL watchdog: simulation did not finish, expected completion");
            $fatal(1, "watchdog");
         end
      join_none

      repeat (3) @(negedge clock);
      #1 chk_reset_outputs("por");
      @(negedge clock) reset_L = 1'b1;
      @(posedge clock); #1 chk_en = 1;

      // nominal window with literal timing pins
      drive_window(16'h0100, MODE_NOM);
      repeat (2) @(posedge clock);
      chk("nom_first_req_cycle", 64'(first_req), 64'd1);
      chk("nom_last_req_cycle",  64'(last_req),  64'd15);
      chk("nom_req_count",       64'(n_iss),     64'd15);
      chk("nom_addr0",  {48'd0, req_addr[0]},  64'h0100);
      chk("nom_addr1",  {48'd0, req_addr[1]},  64'h0140);
      chk("nom_addr14", {48'd0, req_addr[14]}, 64'h0480);
      chk("nom_first_row", first_row, 64'h0100_FEFF_5B5A_1334);
      chk("nom_first_load_cycle", 64'(first_load), 64'd4);
      chk("nom_last_load_cycle",  64'(last_load),  64'd18);
      chk("nom_load_count",       64'(n_load),     64'd15);
      chk("nom_wv_cycle",         64'(wv_rel),     64'd19);
      chk("nom_busy_low_cycle",   64'(busy_fall),  64'd20);
      chk("nom_stall_hold",       64'(stall_hold), 64'd1);

      // wrap around, with an ignored start mid-window
      drive_window(16'hFFC0, MODE_WRAP);
      repeat (2) @(posedge clock);
      chk("wrap_addr0", {48'd0, req_addr[0]}, 64'hFFC0);
      chk("wrap_addr1", {48'd0, req_addr[1]}, 64'h0000);
      chk("wrap_addr2", {48'd0, req_addr[2]}, 64'h0040);
      chk("wrap_loads", 64'(n_load), 64'd15);
      chk("wrap_wv_count", 64'(n_wv), 64'd1);

      // downstream backpressure
      drive_window(16'h1000, MODE_BP);
      repeat (2) @(posedge clock);
      chk("bp_issued_while_blocked", 64'(bp_iss), 64'd4);
      chk("bp_req_while_blocked",    64'(bp_req_cnt), 64'd0);
      chk("bp_loads", 64'(n_load), 64'd15);
      chk("bp_wv_count", 64'(n_wv), 64'd1);
      chk("bp_no_ovf", {63'd0, overflow_err}, 64'd0);

      // grant stall on request 7, start pulsed during DONE
      drive_window(16'h2340, MODE_STALL);
      repeat (3) @(posedge clock);
      #1;
      chk("stall_addr_held_cycles", 64'(stall_hold), 64'd6);
      chk("stall_loads", 64'(n_load), 64'd15);
      chk("stall_wv_count", 64'(n_wv), 64'd1);
      chk("start_in_done_ignored", {63'd0, busy}, 64'd0);

      // reset mid-window after six loads
      drive_window(16'h0400, MODE_RST);
      chk_en = 0;
      mem_en = 0;
      @(negedge clock) reset_L = 1'b0;
      #1 chk_reset_outputs("mid_rst");
      repeat (2) @(negedge clock);
      reset_L = 1'b1;
      @(posedge clock); #1 mem_en = 1;

      // stray read data in IDLE sets the sticky flag
      inject_valid();
      exp_ovf = 1;
      chk("idle_valid_sets_ovf", {63'd0, overflow_err}, 64'd1);
      chk_en = 1;
      drive_window(16'h3000, MODE_NOM);
      repeat (4) @(posedge clock);
      #1;
      chk("post_rst_loads", 64'(n_load), 64'd15);
      chk("post_rst_wv_count", 64'(n_wv), 64'd1);
      chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);

      chk_en = 0;
      @(negedge clock) reset_L = 1'b0;
      exp_ovf = 0;
      #1 chk("ovf_cleared_by_reset", {63'd0, overflow_err}, 64'd0);
      @(negedge clock) reset_L = 1'b1;
      repeat (2) @(posedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
